// File: rtl/moore_multi_ctrl.sv
// moore_multi_ctrl: CH independent S/I Moore channels with dwell delay, global clear, latch history and aggregate status
module moore_multi_ctrl #(
  parameter int CH      = 4,
  parameter int DWELL_W = 8,
  parameter int DWELL   = 3,
  parameter int CNT_W   = 3
) (
  input  logic              Clock,
  input  logic              R,
  input  logic              Clr,
  input  logic [CH-1:0]     S,
  input  logic [CH-1:0]     I,
  output logic [2*CH-1:0]   B,
  output logic [CH-1:0]     Hist,
  output logic              Any_Active,
  output logic [CNT_W-1:0]  Active_Cnt
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, ACTIVE = 2'b11, LATCHED = 2'b10} state_t;
  state_t st [CH];
  state_t nx [CH];
  logic [DWELL_W-1:0] cnt [CH];
  logic [DWELL_W-1:0] cnt_nx [CH];
  logic [CH-1:0] hist_nx;
  logic [CNT_W-1:0] act_nx;
  if (DWELL < 1 || DWELL > 2**DWELL_W - 1) begin : g_bad_dwell
    $error("DWELL out of range");
  end
  if (CH < 1 || CH > 16 || 2**CNT_W <= CH) begin : g_bad_ch
    $error("CH out of range or CNT_W too narrow");
  end
  // Counter defaults to 0 so every state entry restarts the dwell; it only advances while staying ARMED.
  always_comb begin
    act_nx = '0;
    for (int k = 0; k < CH; k++) begin
      nx[k] = st[k];
      cnt_nx[k] = '0;
      hist_nx[k] = Hist[k];
      if (Clr) begin
        nx[k] = IDLE;
        hist_nx[k] = 1'b0;
      end else begin
        case (st[k])
          IDLE:    nx[k] = (I[k] && !S[k]) ? ARMED : IDLE;
          ARMED:
            if (!I[k]) nx[k] = IDLE;
            else if (S[k]) nx[k] = LATCHED;
            else if (cnt[k] == DWELL_W'(DWELL - 1)) nx[k] = ACTIVE;
            else cnt_nx[k] = cnt[k] + 1'b1;
          ACTIVE:
            if (!I[k]) nx[k] = IDLE;
            else if (S[k]) begin
              nx[k] = LATCHED;
              hist_nx[k] = 1'b1;
            end
          default: nx[k] = (!S[k] && !I[k]) ? IDLE : LATCHED;
        endcase
      end
      act_nx = act_nx + CNT_W'(nx[k] == ACTIVE);
    end
  end
  always_ff @(posedge Clock or negedge R) begin
    if (!R) begin
      for (int k = 0; k < CH; k++) begin
        st[k] <= IDLE;
        cnt[k] <= '0;
      end
      Hist <= '0;
      Any_Active <= 1'b0;
      Active_Cnt <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        st[k] <= nx[k];
        cnt[k] <= cnt_nx[k];
      end
      Hist <= hist_nx;
      Any_Active <= act_nx != '0;
      Active_Cnt <= act_nx;
    end
  end
  for (genvar g = 0; g < CH; g++) begin : g_b
    assign B[2*g+:2] = st[g];
  end
endmodule

// File: tb/tb_moore_multi_ctrl.sv
// tb_moore_multi_ctrl: scoreboard bench driving directed and random S/I/Clr/R traffic against a behavioural channel model
module tb_moore_multi_ctrl;
  localparam int CH = 4, DWELL_W = 8, DWELL = 3, CNT_W = 3;
  localparam int W = 3*CH + 1 + CNT_W;
  logic Clock = 1'b0, R = 1'b0, Clr = 1'b0;
  logic [CH-1:0] S = '0, I = '0;
  logic [2*CH-1:0] B;
  logic [CH-1:0] Hist;
  logic Any_Active;
  logic [CNT_W-1:0] Active_Cnt;
  moore_multi_ctrl #(.CH(CH), .DWELL_W(DWELL_W), .DWELL(DWELL), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .R(R), .Clr(Clr), .S(S), .I(I),
    .B(B), .Hist(Hist), .Any_Active(Any_Active), .Active_Cnt(Active_Cnt));
  always #5 Clock = ~Clock;
  // Model modes: 0 idle, 1 armed, 2 active, 3 latched; age = cycles already spent in armed.
  int md [CH];
  int age [CH];
  logic [CH-1:0] hist_m;
  logic [W-1:0] exp_q [$];
  int vectors = 0, miscompares = 0;
  logic [W-1:0] e_v, a_v;
  function automatic logic [1:0] code(int m);
    return m == 1 ? 2'b01 : m == 2 ? 2'b11 : m == 3 ? 2'b10 : 2'b00;
  endfunction
  function automatic logic [W-1:0] expected();
    logic [2*CH-1:0] b;
    int n;
    b = '0;
    n = 0;
    for (int k = 0; k < CH; k++) begin
      b[2*k+:2] = code(md[k]);
      if (md[k] == 2) n++;
    end
    return {b, hist_m, n != 0, CNT_W'(n)};
  endfunction
  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      md[k] = 0;
      age[k] = 0;
    end
    hist_m = '0;
  endtask
  task automatic model_edge(input logic c, input logic [CH-1:0] s, input logic [CH-1:0] i);
    for (int k = 0; k < CH; k++) begin
      if (c) begin
        md[k] = 0;
        hist_m[k] = 1'b0;
      end else if (md[k] == 0) begin
        if (i[k] && !s[k]) begin md[k] = 1; age[k] = 1; end
      end else if (md[k] == 1) begin
        if (!i[k]) md[k] = 0;
        else if (s[k]) md[k] = 3;
        else if (age[k] == DWELL) md[k] = 2;
        else age[k]++;
      end else if (md[k] == 2) begin
        if (!i[k]) md[k] = 0;
        else if (s[k]) begin md[k] = 3; hist_m[k] = 1'b1; end
      end else if (!s[k] && !i[k]) md[k] = 0;
    end
  endtask
  task automatic step(input logic r, input logic c, input logic [CH-1:0] s, input logic [CH-1:0] i);
    @(negedge Clock);
    R = r; Clr = c; S = s; I = i;
    if (!r) model_reset();
    else model_edge(c, s, i);
    exp_q.push_back(expected());
  endtask
  task automatic async_reset();
    @(posedge Clock);
    #3 R = 1'b0;
    #1 vectors++;
    if ({B, Hist, Any_Active, Active_Cnt} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got B=%h Hist=%h any=%b cnt=%0d, want all zero", B, Hist, Any_Active, Active_Cnt);
    end
    model_reset();
  endtask
  always @(posedge Clock) begin
    #1;
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      a_v = {B, Hist, Any_Active, Active_Cnt};
      vectors++;
      if (a_v !== e_v)
        begin
          miscompares++;
          $display("FAIL vec%0d @%0t: got B=%h Hist=%h any=%b cnt=%0d, want B=%h Hist=%h any=%b cnt=%0d",
            vectors, $time, B, Hist, Any_Active, Active_Cnt,
            e_v[W-1-:2*CH], e_v[CH+CNT_W+:CH], e_v[CNT_W], e_v[CNT_W-1:0]);
        end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d vectors", vectors);
    $fatal(1);
  end
  initial begin
    model_reset();
    repeat (3) step(1'b0, 1'b0, '1, '1);
    repeat (5) step(1'b1, 1'b0, '0, 4'b0001);
    repeat (2) step(1'b1, 1'b0, '0, 4'b0011);
    step(1'b1, 1'b0, '0, 4'b0001);
    repeat (5) step(1'b1, 1'b0, '0, 4'b0011);
    repeat (5) step(1'b1, 1'b0, '0, 4'b0111);
    step(1'b1, 1'b0, 4'b0100, 4'b0111);
    repeat (2) step(1'b1, 1'b0, 4'b0100, 4'b0011);
    repeat (2) step(1'b1, 1'b0, '0, 4'b0011);
    repeat (2) step(1'b1, 1'b0, '0, 4'b0000);
    step(1'b1, 1'b0, '0, 4'b0001);
    step(1'b1, 1'b0, '0, 4'b0011);
    step(1'b1, 1'b0, '0, 4'b0111);
    repeat (4) step(1'b1, 1'b0, '0, 4'b1111);
    repeat (2) step(1'b1, 1'b0, '0, 4'b0111);
    step(1'b1, 1'b1, 4'b0001, 4'b0111);
    repeat (2) step(1'b1, 1'b0, '0, 4'b0111);
    repeat (4) step(1'b1, 1'b0, '0, 4'b1111);
    step(1'b1, 1'b0, 4'b0001, 4'b1111);
    step(1'b1, 1'b0, '0, 4'b1101);
    step(1'b1, 1'b0, '0, 4'b1111);
    async_reset();
    repeat (3) step(1'b1, 1'b0, '0, 4'b1111);
    for (int n = 0; n < 3000; n++) begin
      logic [CH-1:0] s_r, i_r;
      for (int k = 0; k < CH; k++) begin
        i_r[k] = $urandom_range(0, 7) != 0;
        s_r[k] = $urandom_range(0, 9) == 0;
      end
      if ($urandom_range(0, 199) == 0) async_reset();
      step($urandom_range(0, 149) != 0, $urandom_range(0, 39) == 0, s_r, i_r);
    end
    repeat (3) @(posedge Clock);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
